// File: rtl/acc_bank_if.sv
// Operation/read bus between the control unit and acc_bank.
// The master drives requests; the slave (acc_bank) returns handshake, read data and flags.
interface acc_bank_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_ACC    = 4
);
  localparam int unsigned SelW = $clog2(NUM_ACC);

  logic                  op_valid;
  logic                  op_ready;
  logic [2:0]            op;
  logic [SelW-1:0]       wr_sel;
  logic [DATA_WIDTH-1:0] data_in;
  logic [SelW-1:0]       rd_sel;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  flag_z;
  logic                  flag_n;
  logic                  flag_c;
  logic                  mul_done;

  modport master (
    output op_valid, op, wr_sel, data_in, rd_sel,
    input  op_ready, data_out, flag_z, flag_n, flag_c, mul_done
  );

  modport slave (
    input  op_valid, op, wr_sel, data_in, rd_sel,
    output op_ready, data_out, flag_z, flag_n, flag_c, mul_done
  );
endinterface

// File: rtl/acc_bank.sv
// Bank of NUM_ACC accumulators with single-cycle ALU ops and flag outputs.
// Define ACC_MUL_EN to add the multi-cycle shift-add MUL (opcode 111); otherwise 111 is a NOP.
module acc_bank #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_ACC    = 4
) (
  input logic         clk,
  input logic         n_rst,
  acc_bank_if.slave   bus
);
  localparam int unsigned SelW = $clog2(NUM_ACC);

  localparam logic [2:0] OpNop  = 3'b000;
  localparam logic [2:0] OpLoad = 3'b001;
  localparam logic [2:0] OpAdd  = 3'b010;
  localparam logic [2:0] OpSub  = 3'b011;
  localparam logic [2:0] OpAnd  = 3'b100;
  localparam logic [2:0] OpXor  = 3'b101;
  localparam logic [2:0] OpShl  = 3'b110;

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t acc_q [NUM_ACC];
  word_t acc_d [NUM_ACC];
  logic  flag_z_q, flag_z_d;
  logic  flag_n_q, flag_n_d;
  logic  flag_c_q, flag_c_d;
  logic  mul_done_q, mul_done_d;

`ifdef ACC_MUL_EN
  localparam logic [2:0]          OpMul   = 3'b111;
  localparam int unsigned         CntW    = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0]     CntLast = CntW'(DATA_WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e                  state_q, state_d;
  logic [2*DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [2*DATA_WIDTH-1:0] prod_q, prod_d;
  logic [2*DATA_WIDTH-1:0] prod_nxt;
  word_t                   mplier_q, mplier_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [SelW-1:0]         tgt_q, tgt_d;
`endif

  logic                  accept;
  word_t                 a_sel;
  logic [DATA_WIDTH:0]   add_w;
  logic [DATA_WIDTH:0]   sub_w;
  word_t                 res;
  logic                  res_c;
  logic                  res_wr;
  logic [SelW-1:0]       wr_idx;

`ifdef ACC_MUL_EN
  assign bus.op_ready = (state_q == StIdle);
`else
  assign bus.op_ready = 1'b1;
`endif

  assign accept = bus.op_valid && bus.op_ready;
  assign a_sel  = acc_q[bus.wr_sel];
  assign add_w  = {1'b0, a_sel} + {1'b0, bus.data_in};
  // MSB of the widened difference is the unsigned borrow.
  assign sub_w  = {1'b0, a_sel} - {1'b0, bus.data_in};

  always_comb begin
    acc_d      = acc_q;
    flag_z_d   = flag_z_q;
    flag_n_d   = flag_n_q;
    flag_c_d   = flag_c_q;
    mul_done_d = 1'b0;
    res        = '0;
    res_c      = 1'b0;
    res_wr     = 1'b0;
    wr_idx     = bus.wr_sel;
`ifdef ACC_MUL_EN
    state_d    = state_q;
    mcand_d    = mcand_q;
    prod_d     = prod_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    prod_nxt   = prod_q;
`endif

    if (accept) begin
      unique case (bus.op)
        OpNop: ;
        OpLoad: begin
          res    = bus.data_in;
          res_wr = 1'b1;
        end
        OpAdd: begin
          {res_c, res} = add_w;
          res_wr       = 1'b1;
        end
        OpSub: begin
          {res_c, res} = sub_w;
          res_wr       = 1'b1;
        end
        OpAnd: begin
          res    = a_sel & bus.data_in;
          res_wr = 1'b1;
        end
        OpXor: begin
          res    = a_sel ^ bus.data_in;
          res_wr = 1'b1;
        end
        OpShl: begin
          res    = {a_sel[DATA_WIDTH-2:0], 1'b0};
          res_c  = a_sel[DATA_WIDTH-1];
          res_wr = 1'b1;
        end
`ifdef ACC_MUL_EN
        OpMul: begin
          state_d  = StMul;
          mcand_d  = {{DATA_WIDTH{1'b0}}, a_sel};
          mplier_d = bus.data_in;
          prod_d   = '0;
          cnt_d    = '0;
          tgt_d    = bus.wr_sel;
        end
`endif
        default: ;
      endcase
    end

`ifdef ACC_MUL_EN
    if (state_q == StMul) begin
      prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);
      prod_d   = prod_nxt;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CntLast) begin
        res        = prod_nxt[DATA_WIDTH-1:0];
        res_c      = |prod_nxt[2*DATA_WIDTH-1:DATA_WIDTH];
        res_wr     = 1'b1;
        wr_idx     = tgt_q;
        mul_done_d = 1'b1;
        state_d    = StIdle;
      end
    end
`endif

    if (res_wr) begin
      acc_d[wr_idx] = res;
      flag_z_d      = (res == '0);
      flag_n_d      = res[DATA_WIDTH-1];
      flag_c_d      = res_c;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        acc_q[i] <= '0;
      end
      flag_z_q   <= 1'b0;
      flag_n_q   <= 1'b0;
      flag_c_q   <= 1'b0;
      mul_done_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      flag_z_q   <= flag_z_d;
      flag_n_q   <= flag_n_d;
      flag_c_q   <= flag_c_d;
      mul_done_q <= mul_done_d;
    end
  end

`ifdef ACC_MUL_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      tgt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      tgt_q    <= tgt_d;
    end
  end
`endif

  assign bus.data_out = acc_q[bus.rd_sel];
  assign bus.flag_z   = flag_z_q;
  assign bus.flag_n   = flag_n_q;
  assign bus.flag_c   = flag_c_q;
  assign bus.mul_done = mul_done_q;
endmodule
